mmio_port_bridge: RTL

MMIO_PORT_BRIDGE -- requirements
Module: mmio_port_bridge

---
 rtl/constants_pkg.sv | 22 ++
 rtl/mmio_in_slot.sv | 30 +++
 rtl/mmio_port_bridge.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/constants_pkg.sv
// Shared defaults and IO-window address helpers for the MMIO bridge.
package constants_pkg;

   localparam int DEF_ADDR_BITS     = 8;
   localparam int DEF_DATA_BITS     = 8;
   localparam int DEF_NUM_OUT_PORTS = 4;
   localparam int DEF_NUM_IN_PORTS  = 2;

   // Output ports sit at the very top of the address space.
   function automatic int out_base(int abits, int n_out);
      return (1 << abits) - n_out;
   endfunction

   function automatic int in_base(int abits, int n_out, int n_in);
      return out_base(abits, n_out) - n_in;
   endfunction

   function automatic int status_addr(int abits, int n_out, int n_in);
      return in_base(abits, n_out, n_in) - 1;
   endfunction

endpackage

// File: rtl/mmio_in_slot.sv
// One-entry input buffer with full flag; capture has priority over clear.
module mmio_in_slot #(
   parameter int D = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [D-1:0] src_data,
   input  logic         src_valid,
   input  logic         clear,
   output logic [D-1:0] data,
   output logic         full
);

   logic capture;

   assign capture = src_valid && !full;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data <= '0;
         full <= 1'b0;
      end else if (capture) begin
         data <= src_data;
         full <= 1'b1;
      end else if (clear) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/mmio_port_bridge.sv
// CPU-to-RAM bridge that carves output ports, input slots and a status
// register out of the top of the address space.
module mmio_port_bridge
   import constants_pkg::*;
#(
   parameter int NUM_OUT_PORTS       = DEF_NUM_OUT_PORTS,
   parameter int NUM_IN_PORTS        = DEF_NUM_IN_PORTS,
   parameter int MEMORY_ADDRESS_BITS = DEF_ADDR_BITS,
   parameter int MEMORY_DATA_BITS    = DEF_DATA_BITS
) (
   input  logic                                      clk,
   input  logic                                      reset_n,
   input  logic                                      rd_mem_en,
   input  logic [MEMORY_ADDRESS_BITS-1:0]            rd_mem_addr,
   input  logic                                      wr_mem_en,
   input  logic [MEMORY_ADDRESS_BITS-1:0]            wr_mem_addr,
   input  logic [MEMORY_DATA_BITS-1:0]               wr_mem_data,
   output logic [MEMORY_DATA_BITS-1:0]               rd_mem_data,
   output logic                                      rd_ram_en,
   output logic [MEMORY_ADDRESS_BITS-1:0]            rd_ram_addr,
   output logic                                      wr_ram_en,
   output logic [MEMORY_ADDRESS_BITS-1:0]            wr_ram_addr,
   output logic [MEMORY_DATA_BITS-1:0]               wr_ram_data,
   input  logic [MEMORY_DATA_BITS-1:0]               rd_ram_data,
   output logic [NUM_OUT_PORTS*MEMORY_DATA_BITS-1:0] out_port_data,
   output logic [NUM_OUT_PORTS-1:0]                  out_port_strobe,
   input  logic [NUM_IN_PORTS*MEMORY_DATA_BITS-1:0]  in_port_data,
   input  logic [NUM_IN_PORTS-1:0]                   in_port_valid,
   output logic [NUM_IN_PORTS-1:0]                   in_port_ready
);

   localparam int A = MEMORY_ADDRESS_BITS;
   localparam int D = MEMORY_DATA_BITS;
   localparam logic [A-1:0] OUT_BASE =
      A'(out_base(A, NUM_OUT_PORTS));
   localparam logic [A-1:0] IN_BASE =
      A'(in_base(A, NUM_OUT_PORTS, NUM_IN_PORTS));
   localparam logic [A-1:0] STATUS =
      A'(status_addr(A, NUM_OUT_PORTS, NUM_IN_PORTS));

   if (NUM_OUT_PORTS < 1 || NUM_OUT_PORTS > 8 ||
       NUM_IN_PORTS < 1 || NUM_IN_PORTS > 7 ||
       D < NUM_IN_PORTS ||
       (1 << A) < NUM_OUT_PORTS + NUM_IN_PORTS + 1) begin : g_bad_params
      $error("mmio_port_bridge: illegal parameter set");
   end

   logic                     rd_io;
   logic                     wr_io;
   logic [D-1:0]             port_q [NUM_OUT_PORTS];
   logic [D-1:0]             slot_data [NUM_IN_PORTS];
   logic [NUM_OUT_PORTS-1:0] wr_hit;
   logic [NUM_IN_PORTS-1:0]  rd_clr;
   logic [NUM_IN_PORTS-1:0]  full;
   logic [D-1:0]             status;
   logic [D-1:0]             io_d;
   logic [D-1:0]             io_q;
   logic                     sel_io;

   // The IO window is contiguous from STATUS up to the top address.
   assign rd_io       = rd_mem_addr >= STATUS;
   assign wr_io       = wr_mem_addr >= STATUS;
   assign rd_ram_en   = rd_mem_en && !rd_io;
   assign wr_ram_en   = wr_mem_en && !wr_io;
   assign rd_ram_addr = rd_mem_addr;
   assign wr_ram_addr = wr_mem_addr;
   assign wr_ram_data = wr_mem_data;

   always_comb begin
      wr_hit = '0;
      rd_clr = '0;
      for (int k = 0; k < NUM_OUT_PORTS; k++)
         wr_hit[k] = wr_mem_en &&
                     (wr_mem_addr == OUT_BASE + A'(k));
      for (int j = 0; j < NUM_IN_PORTS; j++)
         rd_clr[j] = rd_mem_en &&
                     (rd_mem_addr == IN_BASE + A'(j));
   end

   always_comb begin
      status = '0;
      status[NUM_IN_PORTS-1:0] = full;
   end

   always_comb begin
      io_d = '0;
      if (rd_mem_addr == STATUS)
         io_d = status;
      for (int k = 0; k < NUM_OUT_PORTS; k++)
         if (rd_mem_addr == OUT_BASE + A'(k))
            io_d = port_q[k];
      for (int j = 0; j < NUM_IN_PORTS; j++)
         if (rd_mem_addr == IN_BASE + A'(j))
            io_d = slot_data[j];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_OUT_PORTS; k++)
            port_q[k] <= '0;
         out_port_strobe <= '0;
      end else begin
         for (int k = 0; k < NUM_OUT_PORTS; k++)
            if (wr_hit[k])
               port_q[k] <= wr_mem_data;
         out_port_strobe <= wr_hit;
      end
   end

   // Select and IO data only move on a read, so both hold between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_io <= 1'b0;
         io_q   <= '0;
      end else if (rd_mem_en) begin
         sel_io <= rd_io;
         if (rd_io)
            io_q <= io_d;
      end
   end

   assign rd_mem_data   = sel_io ? io_q : rd_ram_data;
   assign in_port_ready = ~full;

   for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
      assign out_port_data[k*D +: D] = port_q[k];
   end

   for (genvar j = 0; j < NUM_IN_PORTS; j++) begin : g_in
      mmio_in_slot #(
         .D(D)
      ) u_slot (
         .clk      (clk),
         .reset_n  (reset_n),
         .src_data (in_port_data[j*D +: D]),
         .src_valid(in_port_valid[j]),
         .clear    (rd_clr[j]),
         .data     (slot_data[j]),
         .full     (full[j])
      );
   end

endmodule
